// File: rtl/modport_barrel_shifter_if.sv
// rtl/modport_barrel_shifter_if.sv - shifter interface bundling operand, controls and registered result
interface modport_barrel_shifter_if #(
    parameter int WIDTH = 4
);
    localparam int SHIFT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   data;
    logic [SHIFT_W-1:0] shift;
    logic               dir;
    logic [WIDTH-1:0]   result;

    modport master (
        output data,
        output shift,
        output dir,
        input  result
    );

    modport slave (
        input  data,
        input  shift,
        input  dir,
        output result
    );
endinterface

// File: rtl/modport_barrel_shifter.sv
// rtl/modport_barrel_shifter.sv - registered log2-stage barrel shifter, 1-cycle latency
// Optional macro BARREL_SHIFTER_ROTATE_EN: rotate instead of zero-fill shift.
module modport_barrel_shifter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    modport_barrel_shifter_if.slave bus
);
    localparam int SHIFT_W = $clog2(WIDTH);

    // Stage k moves by 2^k when amt[k] is set; ternaries keep X on controls visible.
    function automatic logic [WIDTH-1:0] barrel(
        input logic [WIDTH-1:0]   d,
        input logic [SHIFT_W-1:0] amt,
        input logic               right
    );
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] l_s;
        logic [WIDTH-1:0] r_s;
        s = d;
        for (int k = 0; k < SHIFT_W; k++) begin
`ifdef BARREL_SHIFTER_ROTATE_EN
            l_s = (s << (1 << k)) | (s >> (WIDTH - (1 << k)));
            r_s = (s >> (1 << k)) | (s << (WIDTH - (1 << k)));
`else
            l_s = s << (1 << k);
            r_s = s >> (1 << k);
`endif
            s = amt[k] ? (right ? r_s : l_s) : s;
        end
        return s;
    endfunction

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = barrel(bus.data, bus.shift, bus.dir);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.result <= '0;
        end else begin
            bus.result <= shifted;
        end
    end
endmodule

// File: tb/tb_modport_barrel_shifter.sv
// tb/tb_modport_barrel_shifter.sv - scoreboard bench for modport_barrel_shifter
module tb_modport_barrel_shifter;
    localparam int W  = 4;
    localparam int SW = $clog2(W);

    logic clk = 1'b0;
    logic reset;

    modport_barrel_shifter_if #(.WIDTH(W)) sif ();

    modport_barrel_shifter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // Reference: shift/rotate as plain integer arithmetic, truncated to W bits.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s, input logic r);
        int dv;
        int sv;
        int v;
        dv = int'(d);
        sv = int'(s);
`ifdef BARREL_SHIFTER_ROTATE_EN
        v = r ? ((dv >> sv) | (dv << (W - sv))) : ((dv << sv) | (dv >> (W - sv)));
`else
        v = r ? (dv >> sv) : (dv << sv);
`endif
        return v[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [SW-1:0] s, input logic r, input logic [W-1:0] e);
        @(negedge clk);
        sif.data  = d;
        sif.shift = s;
        sif.dir   = r;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        #1 check("reset_async", sif.result, '0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        exp_q.push_back(model(sif.data, sif.shift, sif.dir));
        #1 check("reset_release_hold", sif.result, '0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) check("reset_hold", sif.result, '0);
            else if (exp_q.size() > 0) check("result", sif.result, exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] rnd;
        reset     = 1'b1;
        sif.data  = '0;
        sif.shift = '0;
        sif.dir   = 1'b0;
        #1 check("reset_init", sif.result, '0);
        @(negedge clk);
        #2 reset = 1'b0;
        exp_q.push_back(model(sif.data, sif.shift, sif.dir));

        drive(4'b0101, 2'd1, 1'b0, 4'b1010);
        pulse_reset();

`ifdef BARREL_SHIFTER_ROTATE_EN
        drive(4'b1011, 2'd1, 1'b0, 4'b0111);
        drive(4'b1011, 2'd2, 1'b1, 4'b1110);
        drive(4'b1001, 2'd3, 1'b0, 4'b1100);
        drive(4'b1001, 2'd3, 1'b1, 4'b0011);
`else
        drive(4'b1011, 2'd1, 1'b0, 4'b0110);
        drive(4'b1011, 2'd2, 1'b1, 4'b0010);
        drive(4'b1001, 2'd3, 1'b0, 4'b1000);
        drive(4'b1001, 2'd3, 1'b1, 4'b0001);
`endif
        drive(4'b1001, 2'd0, 1'b0, 4'b1001);
        drive(4'b1001, 2'd0, 1'b1, 4'b1001);

        for (int rep = 0; rep < 2; rep++) begin
            for (int s = 0; s < W; s++) begin
                for (int r = 0; r < 2; r++) begin
                    drive(4'b1101, s[SW-1:0], r[0], model(4'b1101, s[SW-1:0], r[0]));
                end
            end
        end

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) pulse_reset();
            rnd = $urandom();
            drive(rnd[W-1:0], rnd[8 +: SW], rnd[16], model(rnd[W-1:0], rnd[8 +: SW], rnd[16]));
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
